// File: rtl/cache_pkg.sv
// cache_pkg -- definitions shared by the cache and its refill controller.
//   DEFAULT_DATA_WIDTH : default address/data width
//   refill_state_e     : refill FSM state encoding
package cache_pkg;

   localparam int unsigned DEFAULT_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      FILL = 2'd3
   } refill_state_e;

endpackage

// File: rtl/sat_counter.sv
// sat_counter -- up counter that holds at all-ones instead of wrapping.
//   clk   : clock
//   rst_n : asynchronous active-low reset, clears count
//   inc   : increment request for this cycle
//   count : current count value
module sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl -- single-word cache miss refill controller.
//   clk, rst_n                      : clock, asynchronous active-low reset
//   cpu_req, cpu_addr, cache_hit    : CPU load request and cache lookup result
//   stall                           : holds the CPU pipeline during a miss
//   mem_req_valid/ready, mem_addr   : memory read-request handshake
//   mem_resp_valid, mem_rdata       : memory refill response
//   fill_we, fill_addr, fill_data   : one-word write into the cache
//   miss_count                      : saturating count of refills started
//   proto_err                       : sticky flag for unexpected responses
module cache_refill_ctrl
   import cache_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cpu_req,
   input  logic [DATA_WIDTH-1:0] cpu_addr,
   input  logic                  cache_hit,
   output logic                  stall,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic [DATA_WIDTH-1:0] mem_addr,
   input  logic                  mem_resp_valid,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  fill_we,
   output logic [DATA_WIDTH-1:0] fill_addr,
   output logic [DATA_WIDTH-1:0] fill_data,
   output logic [CNT_WIDTH-1:0]  miss_count,
   output logic                  proto_err
);

   // Clearing the byte offset with a mask keeps every cpu_addr bit in use.
   localparam logic [DATA_WIDTH-1:0] WORD_MASK = ~DATA_WIDTH'(3);

   refill_state_e         state_q;
   refill_state_e         state_d;
   logic [DATA_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  proto_err_q;
   logic                  miss;
   logic                  start;

   assign miss  = cpu_req & ~cache_hit;
   assign start = (state_q == IDLE) & miss;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      mem_req_valid = 1'b0;
      fill_we       = 1'b0;
      stall         = 1'b1;
      case (state_q)
         IDLE: begin
            stall = miss;
            if (start) state_d = REQ;
         end
         REQ: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) state_d = WAIT;
         end
         WAIT: begin
            if (mem_resp_valid) state_d = FILL;
         end
         FILL: begin
            fill_we = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q      <= '0;
         data_q      <= '0;
         proto_err_q <= 1'b0;
      end else begin
         if (start) begin
            addr_q <= cpu_addr & WORD_MASK;
         end
         if ((state_q == WAIT) && mem_resp_valid) begin
            data_q <= mem_rdata;
         end
         // A response with no request in flight is a protocol violation.
         if (mem_resp_valid && ((state_q == IDLE) || (state_q == REQ))) begin
            proto_err_q <= 1'b1;
         end
      end
   end

   assign mem_addr  = addr_q;
   assign fill_addr = addr_q;
   assign fill_data = data_q;
   assign proto_err = proto_err_q;

   sat_counter #(
      .WIDTH(CNT_WIDTH)
   ) u_miss_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .inc  (start),
      .count(miss_count)
   );

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl -- directed self-checking bench for cache_refill_ctrl.
// A second instance with a 4-bit miss counter shares all inputs.
module tb_cache_refill_ctrl;

   logic        clk;
   logic        rst_n;
   logic        cpu_req;
   logic [31:0] cpu_addr;
   logic        cache_hit;
   logic        mem_req_ready;
   logic        mem_resp_valid;
   logic [31:0] mem_rdata;

   logic        stall;
   logic        mem_req_valid;
   logic [31:0] mem_addr;
   logic        fill_we;
   logic [31:0] fill_addr;
   logic [31:0] fill_data;
   logic [15:0] miss_count;
   logic        proto_err;

   logic        stall4;
   logic        mem_req_valid4;
   logic [31:0] mem_addr4;
   logic        fill_we4;
   logic [31:0] fill_addr4;
   logic [31:0] fill_data4;
   logic [3:0]  miss_count4;
   logic        proto_err4;

   int unsigned n_checks;
   int unsigned n_pass;
   int unsigned stall_cycles;

   cache_refill_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cpu_req       (cpu_req),
      .cpu_addr      (cpu_addr),
      .cache_hit     (cache_hit),
      .stall         (stall),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_addr      (mem_addr),
      .mem_resp_valid(mem_resp_valid),
      .mem_rdata     (mem_rdata),
      .fill_we       (fill_we),
      .fill_addr     (fill_addr),
      .fill_data     (fill_data),
      .miss_count    (miss_count),
      .proto_err     (proto_err)
   );

   cache_refill_ctrl #(
      .DATA_WIDTH(32),
      .CNT_WIDTH (4)
   ) dut4 (
      .clk           (clk),
      .rst_n         (rst_n),
      .cpu_req       (cpu_req),
      .cpu_addr      (cpu_addr),
      .cache_hit     (cache_hit),
      .stall         (stall4),
      .mem_req_valid (mem_req_valid4),
      .mem_req_ready (mem_req_ready),
      .mem_addr      (mem_addr4),
      .mem_resp_valid(mem_resp_valid),
      .mem_rdata     (mem_rdata),
      .fill_we       (fill_we4),
      .fill_addr     (fill_addr4),
      .fill_data     (fill_data4),
      .miss_count    (miss_count4),
      .proto_err     (proto_err4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full minimum-latency refill starting in IDLE; returns in the cycle after FILL.
   // With chain set, a new miss at next_addr is presented during FILL.
   task automatic refill(input logic [31:0] a, input logic [31:0] d,
                         input bit chain, input logic [31:0] next_addr);
      logic [31:0] ea;
      ea = {a[31:2], 2'b00};
      cpu_req = 1'b1; cache_hit = 1'b0; cpu_addr = a;
      #1;
      check("rf_detect_stall", stall, 1'b1);
      tick();
      cpu_req = 1'b0; mem_req_ready = 1'b1;
      #1;
      check("rf_req_valid", mem_req_valid, 1'b1);
      check("rf_mem_addr", mem_addr, ea);
      tick();
      mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = d;
      #1;
      check("rf_wait_no_fill", fill_we, 1'b0);
      tick();
      mem_resp_valid = 1'b0; mem_rdata = '0; cpu_req = chain; cpu_addr = next_addr;
      #1;
      check("rf_fill_we", fill_we, 1'b1);
      check("rf_fill_addr", fill_addr, ea);
      check("rf_fill_data", fill_data, d);
      tick();
      #1;
      check("rf_after_fill_we", fill_we, 1'b0);
      check("rf_after_fill_stall", stall, chain);
   endtask

   initial begin
      n_checks = 0;
      n_pass = 0;
      rst_n = 1'b1;
      cpu_req = 1'b0; cpu_addr = '0; cache_hit = 1'b0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;

      // Reset values
      #1 rst_n = 1'b0;
      #1;
      check("rst_stall", stall, 1'b0);
      check("rst_req_valid", mem_req_valid, 1'b0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_fill_we", fill_we, 1'b0);
      check("rst_fill_addr", fill_addr, 32'h0);
      check("rst_fill_data", fill_data, 32'h0);
      check("rst_miss_count", miss_count, 16'h0);
      check("rst_proto_err", proto_err, 1'b0);
      cpu_req = 1'b1;
      #1;
      check("rst_stall_comb", stall, 1'b1);
      cpu_req = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;

      // Hits never stall or request
      for (int i = 0; i < 10; i++) begin
         cpu_req = 1'b1; cache_hit = 1'b1; cpu_addr = 32'h100 + 32'(i * 4);
         #1;
         check("hit_stall", stall, 1'b0);
         check("hit_req_valid", mem_req_valid, 1'b0);
         tick();
      end
      cpu_req = 1'b0; cache_hit = 1'b0;
      #1;
      check("hit_miss_count", miss_count, 16'h0);
      tick();

      // Single miss, CPU inputs wiggled outside IDLE
      stall_cycles = 0;
      cpu_req = 1'b1; cache_hit = 1'b0; cpu_addr = 32'h0000_1237;
      #1;
      if (stall) stall_cycles++;
      check("miss_detect_req_valid", mem_req_valid, 1'b0);
      tick();
      cpu_addr = 32'hFFFF_FFF0; mem_req_ready = 1'b1;
      #1;
      if (stall) stall_cycles++;
      check("miss_req_valid", mem_req_valid, 1'b1);
      check("miss_mem_addr", mem_addr, 32'h0000_1234);
      check("miss_count_1", miss_count, 16'd1);
      tick();
      mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      #1;
      if (stall) stall_cycles++;
      check("miss_wait_req_valid", mem_req_valid, 1'b0);
      check("miss_wait_fill_we", fill_we, 1'b0);
      tick();
      mem_resp_valid = 1'b0; mem_rdata = '0; cpu_req = 1'b0;
      #1;
      if (stall) stall_cycles++;
      check("miss_fill_we", fill_we, 1'b1);
      check("miss_fill_addr", fill_addr, 32'h0000_1234);
      check("miss_fill_data", fill_data, 32'hDEAD_BEEF);
      tick();
      #1;
      if (stall) stall_cycles++;
      check("miss_idle_fill_we", fill_we, 1'b0);
      check("miss_stall_cycles", stall_cycles, 4);
      check("miss_count_after", miss_count, 16'd1);
      check("miss_proto_err", proto_err, 1'b0);
      tick();

      // Backpressure: ready held low for 5 cycles
      cpu_req = 1'b1; cache_hit = 1'b0; cpu_addr = 32'h0000_ABCE;
      tick();
      cpu_req = 1'b0;
      for (int i = 0; i < 6; i++) begin
         mem_req_ready = (i == 5);
         #1;
         check("bp_req_valid", mem_req_valid, 1'b1);
         check("bp_mem_addr", mem_addr, 32'h0000_ABCC);
         check("bp_no_fill", fill_we, 1'b0);
         tick();
      end
      mem_req_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         check("bp_wait_req_valid", mem_req_valid, 1'b0);
         check("bp_wait_no_fill", fill_we, 1'b0);
         check("bp_wait_stall", stall, 1'b1);
         tick();
      end
      mem_resp_valid = 1'b1; mem_rdata = 32'h1234_5678;
      tick();
      mem_resp_valid = 1'b0;
      #1;
      check("bp_fill_we", fill_we, 1'b1);
      check("bp_fill_data", fill_data, 32'h1234_5678);
      check("bp_fill_addr", fill_addr, 32'h0000_ABCC);
      tick();
      check("bp_miss_count", miss_count, 16'd2);

      // Back-to-back misses, one IDLE cycle between refills
      refill(32'h0000_0040, 32'hA5A5_0001, 1'b1, 32'h0000_0083);
      refill(32'h0000_0083, 32'h5A5A_0002, 1'b0, 32'h0);
      check("b2b_miss_count", miss_count, 16'd4);
      check("b2b_proto_err", proto_err, 1'b0);

      // Response while IDLE is a protocol error and is not captured
      mem_resp_valid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
      tick();
      mem_resp_valid = 1'b0;
      #1;
      check("perr_set", proto_err, 1'b1);
      check("perr_no_fill", fill_we, 1'b0);
      tick();
      tick();
      check("perr_sticky", proto_err, 1'b1);
      check("perr_data_kept", fill_data, 32'h5A5A_0002);

      // Reset while in WAIT
      cpu_req = 1'b1; cache_hit = 1'b0; cpu_addr = 32'h0000_2000;
      tick();
      cpu_req = 1'b0; mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      check("rstw_req_valid", mem_req_valid, 1'b0);
      check("rstw_stall", stall, 1'b0);
      check("rstw_miss_count", miss_count, 16'h0);
      check("rstw_proto_err", proto_err, 1'b0);
      check("rstw_mem_addr", mem_addr, 32'h0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("rstw_no_fill", fill_we, 1'b0);
         check("rstw_idle_req_valid", mem_req_valid, 1'b0);
         tick();
      end
      mem_resp_valid = 1'b1; mem_rdata = 32'h0BAD_F00D;
      tick();
      mem_resp_valid = 1'b0;
      #1;
      check("late_resp_perr", proto_err, 1'b1);
      check("late_resp_no_fill", fill_we, 1'b0);
      tick();

      // Saturation of the 4-bit counter
      for (int i = 0; i < 17; i++) begin
         refill(32'h0001_0000 + 32'(i * 4), 32'h0000_0100 + 32'(i), 1'b0, 32'h0);
         if (i == 13) check("sat_count_14", miss_count4, 4'hE);
      end
      check("sat_count4", miss_count4, 4'hF);
      check("sat_count16", miss_count, 16'd17);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
